// File: rtl/uart16550_pkg.sv
// Shared UART16550 types and sizing constants, imported by the FIFO blocks
// and by the register file that decodes FCR writes.
package uart16550_pkg;

  localparam int UART16550_TX_FIFO_DEPTH = 16;

  // FCR layout, MSB first. The register file turns fifo_en into fifo_en_i
  // and a write with tx_clr set into the single-cycle clr_i strobe.
  typedef struct packed {
    logic [1:0] rx_trig;
    logic [1:0] reserved;
    logic       dma_mode;
    logic       tx_clr;
    logic       rx_clr;
    logic       fifo_en;
  } fcr_t;

endpackage : uart16550_pkg

// File: rtl/uart16550_fifo_ram.sv
// DEPTH x WIDTH byte store with one synchronous write port and a
// combinational read port; shared by the TX and RX FIFOs.
module uart16550_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; every readable slot is written before the
  // pointers expose it, and a reset term would stop this mapping to RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : uart16550_fifo_ram

// File: rtl/uart16550_tx_fifo.sv
// 16550 transmit holding FIFO: FWFT head byte plus THRE/TEMT status.
// Define UART16550_TX_OVERFLOW_EN to build the sticky write-while-full flag.
module uart16550_tx_fifo
  import uart16550_pkg::*;
#(
  parameter int DEPTH = UART16550_TX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          fifo_en_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [7:0]    d_i,
  input  logic          pop_i,
  output logic [7:0]    q_o,
  output logic          empty_o,
  output logic          full_o,
  input  logic          sr_empty_i,
  output logic          temt_o,
  output logic [LW-1:0] level_o,
  output logic          overflow_o
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          fifo_en_q;
  logic          flush, push_acc, pop_acc;
  logic [7:0]    rdata;

  // A mode change empties the FIFO, so effective depth only ever shrinks
  // while the FIFO is already empty.
  assign flush    = clr_i | (fifo_en_i != fifo_en_q);
  assign empty_o  = (level_q == '0);
  assign full_o   = fifo_en_i ? (level_q >= DEPTH_L) : !empty_o;
  assign push_acc = push_i & (~full_o | pop_i) & ~flush;
  assign pop_acc  = pop_i & ~empty_o & ~flush;

  // NOTE: always_comb assigns every output a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_acc) - LW'(pop_acc);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      fifo_en_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      fifo_en_q <= fifo_en_i;
    end
  end

  uart16550_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (d_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign q_o     = empty_o ? 8'h00 : rdata;
  assign temt_o  = empty_o & sr_empty_i;
  assign level_o = level_q;

`ifdef UART16550_TX_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (flush)                             overflow_d = 1'b0;
    else if (push_i & full_o & ~pop_i)     overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule : uart16550_tx_fifo

// File: tb/tb_uart16550_tx_fifo.sv
// Directed self-checking bench for uart16550_tx_fifo (DEPTH = 16).
module tb_uart16550_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART16550_TX_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni, fifo_en_i, clr_i, push_i, pop_i, sr_empty_i;
  logic [7:0]    d_i, q_o;
  logic          empty_o, full_o, temt_o, overflow_o;
  logic [LW-1:0] level_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model [$];
  logic [7:0] exp_b;
  logic       do_pop;

  uart16550_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .fifo_en_i  (fifo_en_i),
    .clr_i      (clr_i),
    .push_i     (push_i),
    .d_i        (d_i),
    .pop_i      (pop_i),
    .q_o        (q_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .sr_empty_i (sr_empty_i),
    .temt_o     (temt_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    push_i = 1'b1; d_i = b;
    tick();
    push_i = 1'b0;
  endtask

  task automatic pop();
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; fifo_en_i = 1'b0; clr_i = 1'b0; push_i = 1'b0;
    pop_i = 1'b0; sr_empty_i = 1'b1; d_i = 8'h00;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    check("rst_level", 32'(level_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_q", 32'(q_o), 8'h00);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_temt", 32'(temt_o), 1);

    // FIFO mode: the enable change itself flushes, so settle one cycle.
    fifo_en_i = 1'b1; tick();
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("fill_level", 32'(level_o), 16);
    check("fill_full", 32'(full_o), 1);
    check("fill_head", 32'(q_o), 8'h01);
    push(8'h11);
    check("drop_level", 32'(level_o), 16);
    check("drop_ovf", 32'(overflow_o), 32'(OVF));
    for (int i = 1; i <= 16; i++) begin
      check("drain_q", 32'(q_o), 32'(i));
      pop();
    end
    check("drain_empty", 32'(empty_o), 1);
    check("drain_q0", 32'(q_o), 8'h00);
    check("drain_ovf_sticky", 32'(overflow_o), 32'(OVF));
    sr_empty_i = 1'b0; #1;
    check("temt_sr_busy", 32'(temt_o), 0);
    sr_empty_i = 1'b1; #1;
    check("temt_idle", 32'(temt_o), 1);

    // 16450 mode: one-byte holding register.
    fifo_en_i = 1'b0; tick();
    check("mode_ovf_clr", 32'(overflow_o), 0);
    push(8'hA5);
    check("m1_full", 32'(full_o), 1);
    check("m1_q", 32'(q_o), 8'hA5);
    check("m1_temt", 32'(temt_o), 0);
    push(8'h5A);
    check("m1_level", 32'(level_o), 1);
    check("m1_q_kept", 32'(q_o), 8'hA5);
    check("m1_ovf", 32'(overflow_o), 32'(OVF));
    pop();
    check("m1_empty", 32'(empty_o), 1);

    // Full FIFO, simultaneous push and pop.
    fifo_en_i = 1'b1; tick();
    check("m16_ovf_clr", 32'(overflow_o), 0);
    for (int i = 1; i <= 16; i++) push(8'h80 + 8'(i));
    push_i = 1'b1; pop_i = 1'b1; d_i = 8'h77;
    tick();
    push_i = 1'b0; pop_i = 1'b0;
    check("pp_full_level", 32'(level_o), 16);
    check("pp_full_head", 32'(q_o), 8'h82);
    check("pp_full_ovf", 32'(overflow_o), 0);
    for (int i = 2; i <= 17; i++) begin
      exp_b = (i == 17) ? 8'h77 : 8'h80 + 8'(i);
      check("pp_drain_q", 32'(q_o), 32'(exp_b));
      pop();
    end
    check("pp_drain_empty", 32'(empty_o), 1);

    // Empty FIFO, simultaneous push and pop: pop ignored.
    push_i = 1'b1; pop_i = 1'b1; d_i = 8'h33;
    tick();
    push_i = 1'b0; pop_i = 1'b0;
    check("pp_empty_level", 32'(level_o), 1);
    check("pp_empty_q", 32'(q_o), 8'h33);
    pop();

    // Flush via clr_i wins over a concurrent push.
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    check("pre_clr_level", 32'(level_o), 5);
    clr_i = 1'b1; push_i = 1'b1; d_i = 8'hEE;
    tick();
    clr_i = 1'b0; push_i = 1'b0;
    check("clr_level", 32'(level_o), 0);
    check("clr_empty", 32'(empty_o), 1);
    check("clr_ovf", 32'(overflow_o), 0);

    // Flush via mode toggle.
    for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
    check("pre_tog_level", 32'(level_o), 3);
    fifo_en_i = 1'b0; tick();
    check("tog_level", 32'(level_o), 0);
    check("tog_empty", 32'(empty_o), 1);
    fifo_en_i = 1'b1; tick();

    // Stream 20 bytes with a pop every other cycle; crosses the wrap.
    for (int i = 0; i < 20; i++) push(8'hF0 ^ 8'(i));
    model.delete();
    for (int i = 0; i < 10; i++) pop();  // discard pre-fill so pointers sit mid-ring
    while (!empty_o && level_o != 0) pop();
    check("stream_pre_empty", 32'(empty_o), 1);
    for (int i = 0; i < 6; i++) begin push(8'h00); pop(); end
    for (int i = 0; i < 20; i++) begin
      do_pop = (i % 2 == 1) && (model.size() != 0);
      push_i = 1'b1; d_i = 8'hC0 + 8'(i); pop_i = do_pop;
      if (do_pop) check("stream_q", 32'(q_o), 32'(model[0]));
      tick();
      push_i = 1'b0; pop_i = 1'b0;
      if (do_pop) void'(model.pop_front());
      if (model.size() < DEPTH || do_pop) model.push_back(8'hC0 + 8'(i));
      check("stream_level", 32'(level_o), 32'(model.size()));
    end
    sr_empty_i = 1'b1; #1;
    check("stream_temt_busy", 32'(temt_o), 0);
    while (model.size() != 0) begin
      check("stream_drain_q", 32'(q_o), 32'(model.pop_front()));
      pop();
    end
    check("stream_empty", 32'(empty_o), 1);
    check("stream_temt", 32'(temt_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart16550_tx_fifo

// File: doc/uart16550_tx_fifo.md
# uart16550_tx_fifo

Transmit holding FIFO for the 16550-compatible UART. Sits between the APB4 register file (writes to THR) and the transmitter shift-register stage. It buffers up to DEPTH bytes in FIFO mode, or exactly one byte in 16450 (non-FIFO) mode. It supplies first-word-fall-through data plus the LSR THRE/TEMT status to the transmitter and the register file.

## Interface
- DEPTH, 16, FIFO depth in bytes in FIFO mode; power of two, ≥2
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset; synchronous, active-low
- fifo_en_i  input  1  FCR[0]; 1 = FIFO mode, 0 = 16450 mode
- clr_i  input  1  FCR[2] write strobe; single-cycle TX FIFO flush
- push_i  input  1  single-cycle THR write strobe
- d_i  input  8  THR write data
- pop_i  input  1  single-cycle pop from the transmitter
- q_o  output  8  head-of-FIFO byte (FWFT)
- empty_o  output  1  FIFO empty; drives LSR.THRE
- full_o  output  1  FIFO full at the current effective depth
- sr_empty_i  input  1  transmitter shift register empty
- temt_o  output  1  LSR.TEMT = empty_o & sr_empty_i
- level_o  output  $clog2(DEPTH)+1  current byte count
- overflow_o  output  1  sticky write-while-full flag (see Configuration)

## Operation
- State: wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrapping modulo DEPTH. level counter, $clog2(DEPTH)+1 bits. fifo_en_q registers fifo_en_i.
- Effective depth: DEPTH when fifo_en_i=1, otherwise 1.
- full_o = (level ≥ effective depth). empty_o = (level == 0). Both are combinational from registered state.
- Flush: all of the following clear both pointers and level, and discard any push or pop in the same cycle:
  - clr_i=1
  - fifo_en_i != fifo_en_q (mode change, per 16550 semantics)
  - Flush has priority over push and pop.
- Accepted push: push_i & (~full_o | pop_i). Writes d_i to mem[wr_ptr] and increments wr_ptr.
- Push when full without a pop: byte dropped; pointers and level unchanged.
- Accepted pop: pop_i & ~empty_o. Increments rd_ptr.
- Pop when empty: ignored. This includes a push and a pop in the same cycle while empty; the push is accepted and the pop ignored.
- Push and pop both accepted in one cycle: level unchanged, both pointers advance.
- Shrinking effective depth with level > 1 cannot occur, because a mode change always flushes.
- q_o = mem[rd_ptr] when ~empty_o, else 8'h00.
- Storage is not reset; only the pointers and counters are reset.

## Timing
- Reset (rst_ni=0 at a clk_i edge) sets:
  - level_o=0, empty_o=1, full_o=0, q_o=8'h00, overflow_o=0
  - temt_o = sr_empty_i
  - fifo_en_q=0
- Reset takes priority over every other input.
- After a push at edge N: empty_o falls, and q_o shows the byte, after edge N (zero-latency FWFT).
- After a pop at edge N: q_o shows the next byte after edge N.
- The transmitter samples q_o in its idle state and asserts pop_i one cycle later. The head byte must therefore remain stable until pop_i is accepted. Pushes never alter the head while ~empty_o.
- Wrap-around: after DEPTH-1 the pointers return to 0 without a bubble.

## Configuration
- Macro UART16550_TX_OVERFLOW_EN.
- Defined: overflow_o is set on the cycle after a dropped push (push_i & full_o & ~pop_i & ~flush). It stays set until flush or reset.
- Undefined: overflow_o is tied to 0 and no flag register is built.

## Structure
- Package uart16550_pkg holds:
  - UART16550_TX_FIFO_DEPTH (default 16)
  - the fcr_t fields fifo_en and tx_clr, used by the register file to generate fifo_en_i and clr_i
- Sub-module uart16550_fifo_ram holds the storage: DEPTH×8, one write port, combinational read. It is reused by the RX FIFO.

## Test plan
- Reset, then release → level_o=0, empty_o=1, full_o=0, q_o=8'h00, overflow_o=0.
- FIFO mode: push 0x01..0x10 (16 bytes), then 0x11 → full_o=1, level_o=16, 0x11 dropped, overflow_o=1 (macro on). Pop 16 → bytes 0x01..0x10 in order, then empty_o=1.
- 16450 mode (fifo_en_i=0): push 0xA5, then 0x5A → full_o=1 after the first push, q_o=0xA5, 0x5A dropped. Pop → empty_o=1.
- Full FIFO with push 0x77 and pop in the same cycle → level_o stays 16, head advances, 0x77 is read last. Empty FIFO with push 0x33 and pop in the same cycle → level_o=1, q_o=0x33.
- With level_o=5: pulse clr_i together with push_i → level_o=0, empty_o=1, overflow_o=0. Toggle fifo_en_i with level_o=3 → flushed the same way.
- Write 20 bytes while popping one every other cycle across the pointer wrap → data order preserved with no loss until full. temt_o=1 only when empty_o=1 and sr_empty_i=1.
